wb_arbiter: RTL

//  Writeback arbiter feeding the dual-write-port regfile. Collects results from
//  NUM_SRC execution units via valid/ready. Each unit has a 1-entry holding register.

---
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source holding registers, age-ordered same-dest retirement,
// round-robin selection of up to two regfile writes per cycle.
module wb_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned s_width = 32,
    parameter int unsigned s_index = 5,
    parameter bit          DROP_R0 = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*s_index-1:0] src_dest,
    input  logic [NUM_SRC*s_width-1:0] src_data,
    output logic                       ld_a,
    output logic [s_index-1:0]         dest_a,
    output logic [s_width-1:0]         in_a,
    output logic                       ld_b,
    output logic [s_index-1:0]         dest_b,
    output logic [s_width-1:0]         in_b,
    output logic                       prefer_a,
    output logic [NUM_SRC-1:0]         pend_mask,
    output logic                       busy
);
    localparam int unsigned RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [s_index-1:0] hold_dest_q [NUM_SRC];
    logic [s_index-1:0] hold_dest_d [NUM_SRC];
    logic [s_width-1:0] hold_data_q [NUM_SRC];
    logic [s_width-1:0] hold_data_d [NUM_SRC];
    logic [NUM_SRC-1:0] older_q [NUM_SRC];
    logic [NUM_SRC-1:0] older_d [NUM_SRC];
    logic [RR_W-1:0]    rr_q, rr_d;

    logic [NUM_SRC-1:0] elig, granted, capture, set_pend, keep;
    logic               g0_vld, g1_vld;
    logic [RR_W-1:0]    g0_idx, g1_idx, scan_idx;

    // An entry may retire only when no older pending entry targets the same register
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            elig[i] = pend_q[i];
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                if (pend_q[j] && older_q[j][i] && (hold_dest_q[j] == hold_dest_q[i])) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

    // First two eligible entries in round-robin order starting at rr
    always_comb begin
        g0_vld   = 1'b0;
        g1_vld   = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_idx = '0;
        granted  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx = RR_W'((32'(rr_q) + k) % NUM_SRC);
            if (elig[scan_idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = scan_idx;
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                end
            end
        end
        if (g0_vld) granted[g0_idx] = 1'b1;
        if (g1_vld) granted[g1_idx] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (g1_vld) begin
            rr_d = RR_W'((32'(g1_idx) + 32'd1) % NUM_SRC);
        end else if (g0_vld) begin
            rr_d = RR_W'((32'(g0_idx) + 32'd1) % NUM_SRC);
        end
    end

    assign src_ready = {NUM_SRC{rst_n}} & (~pend_q | granted);

    // Capture, retirement and age-matrix maintenance
    always_comb begin
        capture = src_valid & src_ready;
        keep    = pend_q & ~granted;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            set_pend[i] = capture[i] &&
                          !(DROP_R0 && (src_dest[i*s_index +: s_index] == '0));
            hold_dest_d[i] = capture[i] ? src_dest[i*s_index +: s_index] : hold_dest_q[i];
            hold_data_d[i] = capture[i] ? src_data[i*s_width +: s_width] : hold_data_q[i];
        end
        pend_d = keep | set_pend;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            older_d[i] = '0;
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                if (i == j) begin
                    older_d[i][j] = 1'b0;
                end else if (set_pend[i]) begin
                    // simultaneous arrivals: lower index counts as older
                    older_d[i][j] = set_pend[j] && (j > i);
                end else if (set_pend[j]) begin
                    older_d[i][j] = keep[i];
                end else begin
                    older_d[i][j] = older_q[i][j] & keep[i] & keep[j];
                end
            end
        end
    end

    always_comb begin
        ld_a   = g0_vld;
        dest_a = '0;
        in_a   = '0;
        ld_b   = g1_vld;
        dest_b = '0;
        in_b   = '0;
        if (g0_vld) begin
            dest_a = hold_dest_q[g0_idx];
            in_a   = hold_data_q[g0_idx];
        end
        if (g1_vld) begin
            dest_b = hold_dest_q[g1_idx];
            in_b   = hold_data_q[g1_idx];
        end
    end

    assign prefer_a  = 1'b1;
    assign pend_mask = pend_q;
    assign busy      = |pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            rr_q   <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                older_q[i]     <= '0;
                hold_dest_q[i] <= '0;
                hold_data_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            rr_q   <= rr_d;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                older_q[i]     <= older_d[i];
                hold_dest_q[i] <= hold_dest_d[i];
                hold_data_q[i] <= hold_data_d[i];
            end
        end
    end
endmodule
